// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, cache waits and
// EX branch redirects into per-register enables, with saturating perf counters.
module pipeline_stall_controller #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inMemReadIdEx,
    input  logic [REG_ADDR_WIDTH-1:0] inRegisterRdIdEx,
    input  logic [31:0]               inIns,
    input  logic                      inIcacheStall,
    input  logic                      inDcacheStall,
    input  logic                      inBranchTakenEx,
    output logic                      outPCWrite,
    output logic                      outIfIdWrite,
    output logic                      outIfIdFlush,
    output logic                      outCtrlMux,
    output logic                      outIdExWrite,
    output logic                      outExMemWrite,
    output logic                      outMemWbBubble,
    output logic [BUS_DATA_WIDTH-1:0] outStallCount,
    output logic [BUS_DATA_WIDTH-1:0] outFlushCount,
    output logic [1:0]                outState
);

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        DMEM_WAIT     = 2'd1,
        FETCH_DISCARD = 2'd2
    } stateT;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    stateT state, stateNext;

    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2;
    logic                      useRs1, useRs2, loadUse;

    assign opcode = inIns[6:0];
    assign rs1    = REG_ADDR_WIDTH'(inIns[19:15]);
    assign rs2    = REG_ADDR_WIDTH'(inIns[24:20]);
    assign useRs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign useRs2 = (opcode == OP_R) || (opcode == OP_RW) || (opcode == OP_S) || (opcode == OP_B);
    assign loadUse = inMemReadIdEx && (inRegisterRdIdEx != '0) &&
                     ((useRs1 && rs1 == inRegisterRdIdEx) || (useRs2 && rs2 == inRegisterRdIdEx));

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext      = state;
        outPCWrite     = 1'b1;
        outIfIdWrite   = 1'b1;
        outIfIdFlush   = 1'b0;
        outCtrlMux     = 1'b1;
        outIdExWrite   = 1'b1;
        outExMemWrite  = 1'b1;
        outMemWbBubble = 1'b0;

        if (inDcacheStall) begin
            // Whole pipe frozen; EX holds the branch and reasserts it after the wait.
            outPCWrite     = 1'b0;
            outIfIdWrite   = 1'b0;
            outIdExWrite   = 1'b0;
            outExMemWrite  = 1'b0;
            outMemWbBubble = 1'b1;
            stateNext      = (state == FETCH_DISCARD) ? FETCH_DISCARD : DMEM_WAIT;
        end else if (inBranchTakenEx) begin
            outIfIdFlush = 1'b1;
            outCtrlMux   = 1'b0;
            stateNext    = inIcacheStall ? FETCH_DISCARD : RUN;
        end else if (state == FETCH_DISCARD) begin
            // The wrong-path fetch still returns; drop it when it lands.
            outIfIdFlush = 1'b1;
            if (inIcacheStall) outPCWrite = 1'b0;
            else               stateNext  = RUN;
        end else begin
            stateNext = RUN;
            if (loadUse) begin
                outPCWrite   = 1'b0;
                outIfIdWrite = 1'b0;
                outCtrlMux   = 1'b0;
            end else if (inIcacheStall) begin
                outPCWrite   = 1'b0;
                outIfIdFlush = 1'b1;
            end
        end

        if (reset) begin
            outPCWrite     = 1'b0;
            outIfIdWrite   = 1'b1;
            outIfIdFlush   = 1'b1;
            outCtrlMux     = 1'b0;
            outIdExWrite   = 1'b1;
            outExMemWrite  = 1'b1;
            outMemWbBubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outStallCount <= '0;
            outFlushCount <= '0;
        end else begin
            if (!outPCWrite && !(&outStallCount))
                outStallCount <= outStallCount + BUS_DATA_WIDTH'(1);
            if (outIfIdFlush && !(&outFlushCount))
                outFlushCount <= outFlushCount + BUS_DATA_WIDTH'(1);
        end
    end

    assign outState = state;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; small counter width so saturation is reachable.
module tb_pipeline_stall_controller;

    localparam int W = 4;
    localparam logic [1:0] S_RUN = 2'd0, S_DMEM = 2'd1, S_DISC = 2'd2;

    // Control word order: {PCWrite, IfIdWrite, IfIdFlush, CtrlMux, IdExWrite, ExMemWrite, MemWbBubble}
    localparam logic [6:0] C_NORM   = 7'b1101110;
    localparam logic [6:0] C_RESET  = 7'b0110111;
    localparam logic [6:0] C_FREEZE = 7'b0001001;
    localparam logic [6:0] C_BRANCH = 7'b1110110;
    localparam logic [6:0] C_LDUSE  = 7'b0000110;
    localparam logic [6:0] C_ICSTL  = 7'b0111110;
    localparam logic [6:0] C_REL    = 7'b1111110;

    localparam logic [31:0] I_ADD_X5  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] I_ADD_X0  = {7'd0, 5'd1, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] I_LUI_X5  = {20'h00028, 5'd5, 7'b0110111};
    localparam logic [31:0] I_SW_X5   = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] I_ADDI_X1 = {12'h005, 5'd1, 3'd0, 5'd6, 7'b0010011};

    logic         clk = 1'b0;
    logic         reset;
    logic         inMemReadIdEx;
    logic [4:0]   inRegisterRdIdEx;
    logic [31:0]  inIns;
    logic         inIcacheStall, inDcacheStall, inBranchTakenEx;
    logic         outPCWrite, outIfIdWrite, outIfIdFlush, outCtrlMux;
    logic         outIdExWrite, outExMemWrite, outMemWbBubble;
    logic [W-1:0] outStallCount, outFlushCount;
    logic [1:0]   outState;

    int passed = 0;
    int total  = 0;

    pipeline_stall_controller #(.BUS_DATA_WIDTH(W), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .inMemReadIdEx(inMemReadIdEx), .inRegisterRdIdEx(inRegisterRdIdEx), .inIns(inIns),
        .inIcacheStall(inIcacheStall), .inDcacheStall(inDcacheStall),
        .inBranchTakenEx(inBranchTakenEx),
        .outPCWrite(outPCWrite), .outIfIdWrite(outIfIdWrite), .outIfIdFlush(outIfIdFlush),
        .outCtrlMux(outCtrlMux), .outIdExWrite(outIdExWrite), .outExMemWrite(outExMemWrite),
        .outMemWbBubble(outMemWbBubble), .outStallCount(outStallCount),
        .outFlushCount(outFlushCount), .outState(outState)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {outPCWrite, outIfIdWrite, outIfIdFlush, outCtrlMux,
                outIdExWrite, outExMemWrite, outMemWbBubble};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; inMemReadIdEx = 1'b0; inRegisterRdIdEx = 5'd0; inIns = 32'h0000_0013;
        inIcacheStall = 1'b0; inDcacheStall = 1'b0; inBranchTakenEx = 1'b0;
        cyc(); cyc(); settle();
        chk("reset_ctl", ctl(), C_RESET);
        chk("reset_state", outState, S_RUN);
        chk("reset_stallcnt", outStallCount, 0);
        chk("reset_flushcnt", outFlushCount, 0);
        cyc();
        reset = 1'b0;

        // Load-use on rs1
        inMemReadIdEx = 1'b1; inRegisterRdIdEx = 5'd5; inIns = I_ADD_X5; settle();
        chk("lu_ctl", ctl(), C_LDUSE);
        cyc();
        chk("lu_stallcnt", outStallCount, 1);
        inMemReadIdEx = 1'b0; settle();
        chk("lu_after_ctl", ctl(), C_NORM);
        cyc();
        chk("lu_after_stallcnt", outStallCount, 1);

        // x0 destination and LUI never hazard
        inMemReadIdEx = 1'b1; inRegisterRdIdEx = 5'd0; inIns = I_ADD_X0; settle();
        chk("x0_ctl", ctl(), C_NORM);
        cyc();
        inRegisterRdIdEx = 5'd5; inIns = I_LUI_X5; settle();
        chk("lui_ctl", ctl(), C_NORM);
        cyc();
        // rs2 used by store, unused by I-type
        inIns = I_SW_X5; settle();
        chk("sw_rs2_ctl", ctl(), C_LDUSE);
        cyc();
        inIns = I_ADDI_X1; settle();
        chk("addi_rs2_ctl", ctl(), C_NORM);
        cyc();
        inMemReadIdEx = 1'b0;
        chk("hazard_stallcnt", outStallCount, 2);

        // Branch while fetch outstanding
        reset = 1'b1; cyc(); reset = 1'b0;
        inBranchTakenEx = 1'b1; inIcacheStall = 1'b1; settle();
        chk("br_ic_ctl", ctl(), C_BRANCH);
        cyc();
        chk("br_ic_state", outState, S_DISC);
        inBranchTakenEx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("disc_stall_ctl", ctl(), C_ICSTL);
            chk("disc_stall_state", outState, S_DISC);
            cyc();
        end
        inIcacheStall = 1'b0; settle();
        chk("disc_release_ctl", ctl(), C_REL);
        cyc();
        chk("disc_exit_state", outState, S_RUN);
        chk("disc_flushcnt", outFlushCount, 5);
        chk("disc_stallcnt", outStallCount, 3);
        settle();
        chk("disc_done_ctl", ctl(), C_NORM);
        cyc();

        // D-cache freeze with hazard and branch pending
        reset = 1'b1; cyc(); reset = 1'b0;
        inDcacheStall = 1'b1; inBranchTakenEx = 1'b1;
        inMemReadIdEx = 1'b1; inRegisterRdIdEx = 5'd5; inIns = I_ADD_X5;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("dc_freeze_ctl", ctl(), C_FREEZE);
            cyc();
            chk("dc_state", outState, S_DMEM);
        end
        inDcacheStall = 1'b0; settle();
        chk("dc_branch_ctl", ctl(), C_BRANCH);
        chk("dc_stallcnt", outStallCount, 4);
        cyc();
        chk("dc_exit_state", outState, S_RUN);
        chk("dc_flushcnt", outFlushCount, 1);
        inBranchTakenEx = 1'b0; inMemReadIdEx = 1'b0;

        // D-cache stall during discard keeps the discard pending
        inBranchTakenEx = 1'b1; inIcacheStall = 1'b1; cyc();
        inBranchTakenEx = 1'b0; inDcacheStall = 1'b1; settle();
        chk("disc_dc_ctl", ctl(), C_FREEZE);
        cyc();
        chk("disc_dc_state", outState, S_DISC);
        inDcacheStall = 1'b0; inIcacheStall = 1'b0; settle();
        chk("disc_dc_release_ctl", ctl(), C_REL);
        cyc();
        chk("disc_dc_exit_state", outState, S_RUN);

        // Reset while a discard is pending
        inBranchTakenEx = 1'b1; inIcacheStall = 1'b1; cyc();
        chk("rst_disc_pre_state", outState, S_DISC);
        inBranchTakenEx = 1'b0; reset = 1'b1; settle();
        chk("rst_disc_ctl", ctl(), C_RESET);
        cyc();
        chk("rst_disc_state", outState, S_RUN);
        chk("rst_disc_stallcnt", outStallCount, 0);
        chk("rst_disc_flushcnt", outFlushCount, 0);
        reset = 1'b0; inIcacheStall = 1'b0; settle();
        chk("rst_disc_after_ctl", ctl(), C_NORM);
        cyc();
        chk("rst_disc_after_flushcnt", outFlushCount, 0);

        // Counter saturation
        inIcacheStall = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stallcnt", outStallCount, 15);
        chk("sat_flushcnt", outFlushCount, 15);
        cyc();
        chk("sat_hold_stallcnt", outStallCount, 15);
        inIcacheStall = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; instantiated at the top level beside the ID stage.
- Combines load-use hazard detection, I-cache and D-cache wait, and EX-stage taken-branch redirect into per-register write-enable, flush and bubble controls.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
- BUS_DATA_WIDTH, 64, width of the performance counters.
- REG_ADDR_WIDTH, 5, register-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inMemReadIdEx  in  1  ID/EX instruction is a load.
- inRegisterRdIdEx  in  REG_ADDR_WIDTH  destination register of the ID/EX instruction.
- inIns  in  32  instruction currently held in IF/ID.
- inIcacheStall  in  1  fetch not ready this cycle.
- inDcacheStall  in  1  MEM-stage access outstanding this cycle.
- inBranchTakenEx  in  1  EX resolved a taken branch or jump this cycle.
- outPCWrite  out  1  1 = PC updates.
- outIfIdWrite  out  1  1 = IF/ID loads.
- outIfIdFlush  out  1  1 = IF/ID loads a NOP (takes effect only when outIfIdWrite=1).
- outCtrlMux  out  1  1 = pass ID control signals into ID/EX; 0 = zero them (bubble).
- outIdExWrite  out  1  ID/EX register enable.
- outExMemWrite  out  1  EX/MEM register enable.
- outMemWbBubble  out  1  1 = MEM/WB loads a bubble (RegWrite=0).
- outStallCount  out  BUS_DATA_WIDTH  cycles with outPCWrite=0 since reset.
- outFlushCount  out  BUS_DATA_WIDTH  cycles with outIfIdFlush=1 since reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Output mode: all controls are combinational from state plus inputs, except the counters, which are registered.

Reset:
- State goes to RUN; both counters go to 0.
- While reset=1 the outputs are: outPCWrite=0, outIfIdWrite=1, outIfIdFlush=1, outCtrlMux=0, outIdExWrite=1, outExMemWrite=1, outMemWbBubble=1.
- Reset asserted mid-operation discards any pending discard without further effect.

Load-use hazard (loadUse):
- Condition: inMemReadIdEx=1 and inRegisterRdIdEx≠0 and Rd matches a source register in use.
- rs1 (inIns[19:15]) is in use unless the opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
- rs2 (inIns[24:20]) is in use only for opcode R (0110011), R-W (0111011), S (0100011) or B (1100011).

States:
- RUN, DMEM_WAIT, FETCH_DISCARD.

Per-cycle priority (highest first):
- 1 inDcacheStall=1:
  - Freeze: PCWrite=0, IfIdWrite=0, IdExWrite=0, ExMemWrite=0, CtrlMux=1, MemWbBubble=1.
  - Next state is DMEM_WAIT; if the current state is FETCH_DISCARD, it stays FETCH_DISCARD (the discard is preserved).
  - inBranchTakenEx is ignored; EX is held and reasserts the branch after the wait.
- 2 inBranchTakenEx=1:
  - PCWrite=1, IfIdWrite=1, IfIdFlush=1, CtrlMux=0; all other enables 1.
  - If inIcacheStall=1 in the same cycle, the next state is FETCH_DISCARD (the wrong-path fetch is still in flight); otherwise RUN.
- 3 loadUse:
  - PCWrite=0, IfIdWrite=0, CtrlMux=0; IdEx, ExMem and MemWb proceed.
  - Exactly one bubble per hazard; the condition clears naturally the next cycle.
- 4 inIcacheStall=1:
  - PCWrite=0, IfIdWrite=1, IfIdFlush=1 (NOP into decode); downstream proceeds.
- 5 otherwise: all enables 1, IfIdFlush=0, CtrlMux=1, MemWbBubble=0.

FETCH_DISCARD (when not overridden by priority 1 or 2):
- While inIcacheStall=1, behave as priority 4.
- On the first cycle with inIcacheStall=0:
  - PCWrite=1, IfIdWrite=1, IfIdFlush=1 (the returning wrong-path instruction is dropped).
  - Next state is RUN.

DMEM_WAIT:
- Exit to RUN on the first cycle with inDcacheStall=0; that cycle evaluates priorities 2–5 normally.

Counters:
- Increment on a cycle where the corresponding condition holds and reset=0.
- Saturate at all-ones; no wrap.
- Updated values are visible the cycle after the event.

Default outputs:
- Outputs not listed in a case take the priority-5 values.

Test Plan:
- lw writes x5, next add x6,x5,x7 in IF/ID → one cycle PCWrite=0, IfIdWrite=0, CtrlMux=0; the following cycle all 1; outStallCount=1.
- Load to x0 followed by add x6,x0,x1; then load to x5 followed by lui x5 → no stall in either case (x0 excluded; rs fields unused by LUI).
- inBranchTakenEx=1 together with inIcacheStall=1 for 3 cycles → IfIdFlush=1 on the branch cycle, the 3 stall cycles, and the release cycle; PCWrite=1 only on the branch and release cycles; state returns to RUN; outFlushCount=5.
- inDcacheStall=1 for 4 cycles with a loadUse and a branch pending → all enables 0 and MemWbBubble=1 for 4 cycles; the branch flush follows on cycle 5; outStallCount=4.
- Reset asserted in FETCH_DISCARD → next cycle state is RUN, counters 0, outputs at reset values while reset is high; no discard after release.
- Force outStallCount to all-ones, then stall → the value holds at all-ones.
